// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scan controller.
// Per frame, the BCD value, dp mask and lzb flag are snapshotted into shadows.
// Each digit slot opens with an all-off gap and then drives that digit's
// enable and its segment code. All outputs are registered, one cycle behind
// the (cnt, idx) state that produced them.

// Per-digit decoder: BCD nibble -> active-low {dp,g..a}.
// A suppressed (leading-zero) digit keeps its dp but blanks g..a.
module seg_lane (
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       sup,
  output logic [7:0] code
);
  logic [6:0] s7;

  // Segment lookup; codes 10..15 light segment a only
  always_comb begin
    s7 = 7'h7e;
    case (nib)
      4'd0: s7 = 7'h40;
      4'd1: s7 = 7'h79;
      4'd2: s7 = 7'h24;
      4'd3: s7 = 7'h30;
      4'd4: s7 = 7'h19;
      4'd5: s7 = 7'h12;
      4'd6: s7 = 7'h02;
      4'd7: s7 = 7'h78;
      4'd8: s7 = 7'h00;
      4'd9: s7 = 7'h10;
      default: s7 = 7'h7e;
    endcase
    if (sup) s7 = 7'h7f;
    code = {~dp, s7};
  end
endmodule

module seg_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  lzb,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  frame_done
);
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]             cnt;
  logic [IDX_W-1:0]             idx;
  logic [DIGITS-1:0][3:0]       sh_val;
  logic [DIGITS-1:0]            sh_dp;
  logic                         sh_lzb;
  // Set on the wrap edge so frame_done lands on slot 0's first output cycle
  logic                         wrap_q;

  logic                         last_cnt;
  logic                         last_idx;
  logic                         show;
  logic [DIGITS:0]              hz;       // hz[i]: nibbles DIGITS-1..i all zero
  logic [DIGITS-1:0]            sup;
  logic [DIGITS-1:0][7:0]       lane_seg;
  logic [DIGITS-1:0]            an_nxt;
  logic [7:0]                   seg_nxt;

  assign last_cnt = (32'(cnt) == SCAN_DIV - 1);
  assign last_idx = (32'(idx) == DIGITS - 1);
  assign show     = (32'(cnt) >= BLANK_CYCLES);

  // Leading-zero chain runs from the most significant digit downward;
  // digit 0 is never suppressed so a zero value still shows "0".
  assign hz[DIGITS] = 1'b1;
  assign sup = {hz[DIGITS-1:1] & {(DIGITS-1){sh_lzb}}, 1'b0};

  for (genvar i = 0; i < DIGITS; i++) begin : g_lane
    assign hz[i] = hz[i+1] & (sh_val[i] == 4'd0);
    seg_lane u_lane (
      .nib  (sh_val[i]),
      .dp   (sh_dp[i]),
      .sup  (sup[i]),
      .code (lane_seg[i])
    );
  end

  // Output selection for the current (cnt, idx): blank gap, then one digit
  always_comb begin
    an_nxt  = '1;
    seg_nxt = 8'hff;
    if (show) begin
      an_nxt[idx] = 1'b0;
      seg_nxt     = lane_seg[idx];
    end
  end

  // Slot counter and digit rotation; en low parks the scanner at digit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      wrap_q <= 1'b0;
    end else if (!en) begin
      cnt    <= '0;
      idx    <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (last_cnt) begin
        cnt <= '0;
        if (last_idx) begin
          idx    <= '0;
          wrap_q <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Shadows: track inputs while disabled, otherwise reload only at frame wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_val <= '0;
      sh_dp  <= '0;
      sh_lzb <= 1'b0;
    end else if (!en || (last_cnt && last_idx)) begin
      sh_val <= value;
      sh_dp  <= dp_mask;
      sh_lzb <= lzb;
    end
  end

  // Registered pin drivers; everything off while disabled or in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= '1;
      seg        <= 8'hff;
      frame_done <= 1'b0;
    end else if (!en) begin
      an         <= '1;
      seg        <= 8'hff;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_done <= wrap_q;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
module tb_seg_scan_ctrl;
  localparam int DIGITS = 4;
  localparam int SDIV   = 8;
  localparam int BLNK   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        lzb;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  seg_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SDIV), .BLANK_CYCLES(BLNK)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .value      (value),
    .dp_mask    (dp_mask),
    .lzb        (lzb),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step one full frame from slot 0, cnt 0; compares {an,seg,frame_done}
  // every cycle. Optionally changes value after output cycle chg_at.
  task automatic frame_chk(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3, input logic fd0,
                           input int chg_at, input logic [15:0] chg_val);
    logic [7:0] s [4];
    logic [3:0] ea;
    logic [7:0] es;
    logic       ef;
    s = '{s0, s1, s2, s3};
    for (int d = 0; d < DIGITS; d++) begin
      for (int c = 0; c < SDIV; c++) begin
        tick();
        ea = 4'hf;
        es = 8'hff;
        if (c >= BLNK) begin
          ea[d] = 1'b0;
          es    = s[d];
        end
        ef = (d == 0 && c == 0) ? fd0 : 1'b0;
        chk($sformatf("%s d%0d c%0d", tag, d, c), {3'b0, an, seg, frame_done},
            {3'b0, ea, es, ef});
        if (d * SDIV + c == chg_at) value = chg_val;
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; value = 16'h0; dp_mask = 4'h0; lzb = 1'b0;
    #2;
    chk("reset", {3'b0, an, seg, frame_done}, {3'b0, 4'hf, 8'hff, 1'b0});
    tick(); tick();
    rst = 1'b0;
    value = 16'h1234;  // not visible until the frame wrap
    frame_chk("rel", 8'hc0, 8'hc0, 8'hc0, 8'hc0, 1'b0, -1, 16'h0);
    value = 16'h0050; lzb = 1'b1;
    frame_chk("basic", 8'h99, 8'hb0, 8'ha4, 8'hf9, 1'b1, -1, 16'h0);
    value = 16'h0000;
    frame_chk("lzb50", 8'hc0, 8'h92, 8'hff, 8'hff, 1'b1, -1, 16'h0);
    value = 16'h00a9; dp_mask = 4'b0100; lzb = 1'b0;
    frame_chk("lzb0", 8'hc0, 8'hff, 8'hff, 8'hff, 1'b1, -1, 16'h0);
    value = 16'h1111; dp_mask = 4'b0000;
    frame_chk("dp", 8'h90, 8'hfe, 8'h40, 8'hc0, 1'b1, -1, 16'h0);
    frame_chk("snap", 8'hf9, 8'hf9, 8'hf9, 8'hf9, 1'b1, 12, 16'h2222);
    frame_chk("snap2", 8'ha4, 8'ha4, 8'ha4, 8'ha4, 1'b1, -1, 16'h0);

    // Drop en partway into slot 2
    for (int i = 0; i < 20; i++) tick();
    chk("pre_dis", {3'b0, an, seg, frame_done}, {3'b0, 4'hb, 8'ha4, 1'b0});
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("dis%0d", i), {3'b0, an, seg, frame_done}, {3'b0, 4'hf, 8'hff, 1'b0});
    end
    value = 16'h0007;
    tick();
    chk("dis_last", {3'b0, an, seg, frame_done}, {3'b0, 4'hf, 8'hff, 1'b0});
    en = 1'b1;
    frame_chk("restart", 8'hf8, 8'hc0, 8'hc0, 8'hc0, 1'b0, -1, 16'h0);

    // Async reset mid-SHOW of digit 0
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst", {3'b0, an, seg, frame_done}, {3'b0, 4'he, 8'hf8, 1'b0});
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", {3'b0, an, seg, frame_done}, {3'b0, 4'hf, 8'hff, 1'b0});
    value = 16'h0;
    tick();
    rst = 1'b0;
    frame_chk("post_rst", 8'hc0, 8'hc0, 8'hc0, 8'hc0, 1'b0, -1, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode 7-segment digits sharing one segment bus. It snapshots a packed BCD value once per frame, walks the digit enables in a fixed rotation and decodes the selected nibble onto the shared segment lines. It inserts a blanking gap between digits to suppress ghosting and supports leading-zero blanking and per-digit decimal points. It sits between the numeric datapath (counter/timer values) and the board's anode/segment pins.

## Interface

- DIGITS, 4, number of digits scanned (2..8)
- SCAN_DIV, 50000, clock cycles per digit slot (>= 2)
- BLANK_CYCLES, 500, all-off cycles at the start of every slot (0 <= BLANK_CYCLES < SCAN_DIV)

- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  scan enable; low blanks the display and parks the scanner
- value  input  4*DIGITS  packed BCD; nibble i (bits 4i+3:4i) drives digit i, digit 0 least significant
- dp_mask  input  DIGITS  bit i high lights the decimal point of digit i
- lzb  input  1  leading-zero blanking enable
- an  output  DIGITS  digit enables, active-low, one-hot-low or all-high
- seg  output  8  {dp,g,f,e,d,c,b,a}, active-low
- frame_done  output  1  one-cycle pulse at each frame boundary / snapshot load

## Operation

- Segment code per nibble: 0=c0, 1=f9, 2=a4, 3=b0, 4=99, 5=92, 6=82, 7=f8, 8=80, 9=90; 10..15 = fe (segment a only). Lit dp clears bit 7.
- Internal state: slot counter cnt (0..SCAN_DIV-1), digit index idx (0..DIGITS-1), shadow registers for value, dp_mask, lzb.
- cnt increments every cycle while en=1. At cnt=SCAN_DIV-1 it wraps to 0 and idx advances. idx wraps DIGITS-1 -> 0.
- Per slot there are two phases:
  - BLANK (cnt < BLANK_CYCLES): an = all 1, seg = ff.
  - SHOW (cnt >= BLANK_CYCLES): an[idx]=0, all other an bits 1, and seg = code(shadow nibble idx) with the dp bit = ~shadow_dp[idx].
- Leading-zero blanking: with shadow lzb=1, digit i (i>0) is suppressed if every shadow nibble from DIGITS-1 down to i is 0.
  - A suppressed digit still gets its an slot, but seg[6:0]=7f; its dp still obeys dp_mask.
  - Digit 0 is never suppressed.
- Shadow load happens on the edge where idx wraps DIGITS-1 -> 0. The same edge registers frame_done=1 for one cycle.
- While en=0, the shadows load every cycle, so they track the inputs continuously.
- Inputs changing mid-frame have no visible effect until the next frame.
- en=0: cnt and idx clear to 0. Outputs go to an = all 1, seg = ff and frame_done = 0 on the next edge. Hold as long as en=0.
- en 0 -> 1: scanning restarts at digit 0, cnt=0, using the shadows loaded on the last en=0 cycle. No frame_done pulse at restart.

## Timing

- Reset (async, immediate): an = all 1, seg = ff, frame_done = 0, cnt = 0, idx = 0, shadows = 0.
- Release: the first rising edge with rst low and en=1 begins slot 0.
- All outputs are registered. an, seg and frame_done reflect the (cnt, idx) of the previous cycle, a 1-cycle latency.
- Per slot: exactly BLANK_CYCLES cycles all-off, then SCAN_DIV - BLANK_CYCLES cycles with that digit enabled.
- Frame length is DIGITS*SCAN_DIV cycles, so frame_done has that period in steady state.
- frame_done is high in the first output cycle of slot 0, which is a blank cycle when BLANK_CYCLES > 0.
- With BLANK_CYCLES=0, consecutive digits switch an and seg on the same edge, with no all-off cycle.
- rst asserted mid-slot: outputs are forced off asynchronously. After release the scan resumes at digit 0 with the shadows = 0.
- en falling on the wrap edge: en=0 has priority, so there is no frame_done and no idx advance.

## Test plan

All scenarios use DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.

- Reset: assert rst mid-SHOW -> an=f and seg=ff in the same cycle (no clock edge needed), frame_done=0. Release with value=0 -> digit 0 shows c0 and digits 1..3 show c0.
- Basic scan: value=16'h1234, dp_mask=0, lzb=0 -> per slot 2 cycles an=f/seg=ff, then 6 cycles of:
  - an=e, seg=99
  - an=d, seg=b0
  - an=b, seg=a4
  - an=7, seg=f9
  - frame_done pulses every 32 cycles.
- LZB: value=16'h0050, lzb=1 -> digits 3 and 2 show seg=ff with their an slots still active, digit 1 shows 92, digit 0 shows c0. value=0 with lzb=1 -> only digit 0 shows c0.
- DP and out-of-range: value=16'h00A9, dp_mask=4'b0100 -> digit 2 shows 40, digit 1 shows fe, digit 0 shows 90.
- Snapshot: change value 16'h1111 -> 16'h2222 mid-slot 1 -> remaining slots show f9; 2222 (a4) appears only after the next frame_done.
- Enable: drop en in slot 2 -> next edge an=f, seg=ff, held. Raise en with value=16'h0007 -> restart at digit 0 (f8) after 2 blank cycles, with no frame_done.
